// File: rtl/nc_inv_chk_arb.sv
// Collects per-core non-cacheable-load I$ invalidation violations and serializes
// them onto one report channel. It uses a round-robin arbiter and keeps saturating
// counters for accepted and dropped events.
module nc_inv_chk_arb #(
   parameter int N_CORES = 4,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 chk_enable,
   input  logic [N_CORES-1:0]   viol_vld,
   input  logic [4*N_CORES-1:0] viol_code,
   output logic                 rpt_vld,
   input  logic                 rpt_rdy,
   output logic [9:0]           rpt_coreid,
   output logic [3:0]           rpt_code,
   output logic                 rpt_fatal,
   output logic                 fail_seen,
   output logic [CNT_W-1:0]     evt_cnt,
   output logic [CNT_W-1:0]     drop_cnt
);

   localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam int SUM_W = CNT_W + 8;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_CORES - 1);

   logic [0:0]         state_q, state_d;
   logic [PTR_W-1:0]   rr_q, rr_d;
   logic [N_CORES-1:0] slot_vld_q, slot_vld_d;
   logic [3:0]         slot_code_q [N_CORES];
   logic [3:0]         slot_code_d [N_CORES];
   logic [N_CORES-1:0] slot_fatal_q, slot_fatal_d;
   logic [9:0]         rpt_coreid_q, rpt_coreid_d;
   logic [3:0]         rpt_code_q, rpt_code_d;
   logic               rpt_fatal_q, rpt_fatal_d;
   logic               fail_seen_q, fail_seen_d;
   logic [CNT_W-1:0]   evt_cnt_q, evt_cnt_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

   logic               gnt_found;
   logic [PTR_W-1:0]   gnt_idx;
   logic               accept;
   logic               grant;
   logic [N_CORES-1:0] drop_vec;
   logic [SUM_W-1:0]   drop_pop;
   logic [SUM_W-1:0]   drop_sum;

   // Round-robin search: first valid slot at or above the pointer, wrapping to 0.
   always_comb begin
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < N_CORES; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= N_CORES) begin
            idx = idx - N_CORES;
         end
         if (!gnt_found && slot_vld_q[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = PTR_W'(idx);
         end
      end
   end

   assign accept = (state_q == ST_SEND) && rpt_rdy;
   assign grant  = gnt_found && ((state_q == ST_IDLE) || accept);

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      rpt_coreid_d = rpt_coreid_q;
      rpt_code_d   = rpt_code_q;
      rpt_fatal_d  = rpt_fatal_q;
      fail_seen_d  = fail_seen_q | (accept & rpt_fatal_q);
      evt_cnt_d    = evt_cnt_q;
      if (accept && (evt_cnt_q != CNT_MAX)) begin
         evt_cnt_d = evt_cnt_q + 1'b1;
      end
      if (grant) begin
         state_d      = ST_SEND;
         rr_d         = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
         rpt_coreid_d = 10'(gnt_idx);
         rpt_code_d   = slot_code_q[gnt_idx];
         rpt_fatal_d  = slot_fatal_q[gnt_idx];
      end else if (accept) begin
         state_d = ST_IDLE;
      end
   end

   // A slot being granted this edge counts as free, so a new event replaces it.
   always_comb begin
      slot_vld_d   = slot_vld_q;
      slot_fatal_d = slot_fatal_q;
      drop_vec     = '0;
      drop_pop     = '0;
      for (int i = 0; i < N_CORES; i++) begin
         logic slot_free;
         slot_free      = grant && (gnt_idx == PTR_W'(i));
         slot_code_d[i] = slot_code_q[i];
         if (viol_vld[i] && (!slot_vld_q[i] || slot_free)) begin
            slot_vld_d[i]   = 1'b1;
            slot_code_d[i]  = viol_code[4*i +: 4];
            slot_fatal_d[i] = chk_enable;
         end else if (viol_vld[i]) begin
            drop_vec[i] = 1'b1;
         end else if (slot_free) begin
            slot_vld_d[i] = 1'b0;
         end
         drop_pop = drop_pop + SUM_W'(drop_vec[i]);
      end
      drop_sum   = SUM_W'(drop_cnt_q) + drop_pop;
      drop_cnt_d = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rr_q         <= '0;
         slot_vld_q   <= '0;
         slot_fatal_q <= '0;
         for (int i = 0; i < N_CORES; i++) begin
            slot_code_q[i] <= '0;
         end
         rpt_coreid_q <= '0;
         rpt_code_q   <= '0;
         rpt_fatal_q  <= 1'b0;
         fail_seen_q  <= 1'b0;
         evt_cnt_q    <= '0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         slot_vld_q   <= slot_vld_d;
         slot_fatal_q <= slot_fatal_d;
         for (int i = 0; i < N_CORES; i++) begin
            slot_code_q[i] <= slot_code_d[i];
         end
         rpt_coreid_q <= rpt_coreid_d;
         rpt_code_q   <= rpt_code_d;
         rpt_fatal_q  <= rpt_fatal_d;
         fail_seen_q  <= fail_seen_d;
         evt_cnt_q    <= evt_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign rpt_vld    = (state_q == ST_SEND);
   assign rpt_coreid = rpt_coreid_q;
   assign rpt_code   = rpt_code_q;
   assign rpt_fatal  = rpt_fatal_q;
   assign fail_seen  = fail_seen_q;
   assign evt_cnt    = evt_cnt_q;
   assign drop_cnt   = drop_cnt_q;

endmodule
